// File: rtl/dhash.sv
// dhash: 64-bit difference hash of 640x480 grayscale frames with Hamming-distance motion detection over a CI port
module dhash #(
    parameter logic [7:0] customId = 8'h27
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        camClock,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        validCamera,
    input  logic [7:0]  camData,
    input  logic        takeSignature,
    input  logic        ciStart,
    input  logic [7:0]  ciN,
    input  logic [31:0] ciValueA,
    input  logic [31:0] ciValueB,
    output logic        ciDone,
    output logic [31:0] ciResult
);
    logic        enable, busy, frameDone, sigValid, motion;
    logic [6:0]  threshold, distance, popCount;
    logic [7:0]  frameCount, bandBits;
    logic [9:0]  x;
    logic [5:0]  lineInBand;
    logic [2:0]  band;
    logic [63:0] hash, reference, newHash;
    logic [19:0] acc [9];
    logic [19:0] accNext [9];
    logic [31:0] readWord;
    logic        selected, active, pixelHit, bandEnd, unusedBits;
    logic [3:0]  cmd;

    assign unusedBits = ^{camClock, ciValueA[31:13], ciValueA[8:2], ciValueB[31:7]};
    assign selected   = ciStart && ciN == customId;
    assign cmd        = ciValueA[12:9];
    assign active     = busy && !frameDone;
    assign pixelHit   = active && validCamera && x < 10'd576;
    assign bandEnd    = active && hsync && lineInBand == 6'd59;

    // Column sums including this cycle's pixel, so a pixel arriving with hsync lands in its band
    always_comb begin
        for (int i = 0; i < 9; i++)
            accNext[i] = acc[i] + ((pixelHit && x[9:6] == 4'(i)) ? {12'b0, camData} : 20'd0);
        for (int c = 0; c < 8; c++)
            bandBits[c] = accNext[c] < accNext[c+1];
    end

    // Hamming distance between the finished frame's hash and the stored reference
    always_comb begin
        popCount = '0;
        for (int i = 0; i < 64; i++)
            popCount = popCount + 7'(newHash[i] ^ reference[i]);
    end

    // CI read mux; writes and unknown codes return zero
    always_comb begin
        readWord = ciValueA[1:0] == 2'd0 ? hash[31:0] :
                   ciValueA[1:0] == 2'd1 ? hash[63:32] :
                   ciValueA[1:0] == 2'd2 ? {25'b0, distance} :
                   {16'b0, frameCount, 4'b0, busy, enable, sigValid, motion};
        ciDone   = selected;
        ciResult = (selected && cmd == 4'h0) ? readWord : 32'h0;
    end

    // CI configuration writes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enable    <= 1'b0;
            threshold <= '0;
        end else if (selected) begin
            if (cmd == 4'h9) threshold <= ciValueB[6:0];
            if (cmd == 4'hA) enable <= 1'b0;
            if (cmd == 4'hB) enable <= 1'b1;
        end
    end

    // Frame capture: pixel accumulation, band finalisation into the working hash
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy       <= 1'b0;
            frameDone  <= 1'b0;
            x          <= '0;
            lineInBand <= '0;
            band       <= '0;
            newHash    <= '0;
            for (int i = 0; i < 9; i++) acc[i] <= '0;
        end else if (vsync && enable) begin
            busy       <= 1'b1;
            frameDone  <= 1'b0;
            x          <= '0;
            lineInBand <= '0;
            band       <= '0;
            newHash    <= '0;
            for (int i = 0; i < 9; i++) acc[i] <= '0;
        end else if (frameDone) begin
            busy      <= 1'b0;
            frameDone <= 1'b0;
        end else if (busy) begin
            for (int i = 0; i < 9; i++) acc[i] <= bandEnd ? 20'd0 : accNext[i];
            if (validCamera && x != 10'd1023) x <= x + 10'd1;
            if (hsync) begin
                x          <= '0;
                lineInBand <= bandEnd ? 6'd0 : lineInBand + 6'd1;
                if (bandEnd) begin
                    newHash[{band, 3'b000} +: 8] <= bandBits;
                    band      <= band + 3'd1;
                    frameDone <= band == 3'd7;
                end
            end
        end
    end

    // Publish results one cycle after the last line; distance is only meaningful once a reference exists
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hash       <= '0;
            reference  <= '0;
            sigValid   <= 1'b0;
            distance   <= '0;
            motion     <= 1'b0;
            frameCount <= '0;
        end else if (frameDone) begin
            hash       <= newHash;
            distance   <= sigValid ? popCount : 7'd0;
            motion     <= sigValid && popCount > threshold;
            frameCount <= frameCount + 8'd1;
            if (takeSignature) begin
                reference <= newHash;
                sigValid  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dhash.sv
// tb_dhash: directed frames against a frame-level dHash model plus literal expectations
module tb_dhash;
    logic        clock_tb = 1'b0;
    logic        reset, hsync, vsync, validCamera, takeSignature, ciStart, ciDone;
    logic [7:0]  camData, ciN;
    logic [31:0] ciValueA, ciValueB, ciResult, r;
    int          vectors = 0, miscompares = 0;
    bit          checkOn = 1'b0;
    logic [63:0] expHash, expRef;
    logic [6:0]  expDist, expThr;
    logic [7:0]  expFc;
    logic        expSig, expMot, expEn, expBusy;

    dhash dut (
        .clock(clock_tb), .reset(reset), .camClock(clock_tb), .hsync(hsync), .vsync(vsync),
        .validCamera(validCamera), .camData(camData), .takeSignature(takeSignature),
        .ciStart(ciStart), .ciN(ciN), .ciValueA(ciValueA), .ciValueB(ciValueB),
        .ciDone(ciDone), .ciResult(ciResult)
    );

    always #5 clock_tb = ~clock_tb;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clock_tb);
        #1;
    endtask

    function automatic logic [7:0] pix(input int mode, input int x, input int y);
        case (mode)
            0: return 8'(x % 256);
            2: return 8'((x * 7 + y * 13) % 256);
            3: return (y % 60 == 59 && x == 575) ? 8'hFF : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    function automatic int lineLen(input int y);
        return (y % 60 == 0) ? 590 : (y % 60 == 59) ? 576 : 0;
    endfunction

    function automatic logic [63:0] frameHash(input int mode);
        longint sums [8][9];
        logic [63:0] h;
        h = '0;
        for (int b = 0; b < 8; b++)
            for (int c = 0; c < 9; c++) sums[b][c] = 0;
        for (int y = 0; y < 480; y++)
            for (int x = 0; x < lineLen(y); x++)
                if (x < 576) sums[y / 60][x / 64] += longint'(pix(mode, x, y));
        for (int b = 0; b < 8; b++)
            for (int c = 0; c < 8; c++) h[b * 8 + c] = sums[b][c] < sums[b][c + 1];
        return h;
    endfunction

    function automatic logic [31:0] modelWord(input logic [1:0] idx);
        case (idx)
            2'd0: return expHash[31:0];
            2'd1: return expHash[63:32];
            2'd2: return {25'b0, expDist};
            default: return {16'b0, expFc, 4'b0, expBusy, expEn, expSig, expMot};
        endcase
    endfunction

    task automatic modelReset();
        expHash = '0; expRef = '0; expDist = '0; expThr = '0; expFc = '0;
        expSig = 0; expMot = 0; expEn = 0; expBusy = 0;
    endtask

    task automatic modelComplete(input logic [63:0] h, input logic take);
        logic [6:0] d;
        d = expSig ? 7'($countones(h ^ expRef)) : 7'd0;
        expMot  = expSig && d > expThr;
        expDist = d;
        expHash = h;
        expFc   = expFc + 8'd1;
        expBusy = 0;
        if (take) begin
            expRef = h;
            expSig = 1;
        end
    endtask

    always @(negedge clock_tb) begin
        if (checkOn) begin
            logic sel;
            logic [31:0] want;
            sel  = ciStart && ciN == 8'h27;
            want = (sel && ciValueA[12:9] == 4'h0) ? modelWord(ciValueA[1:0]) : 32'h0;
            check("ciDone", {31'b0, ciDone}, {31'b0, sel});
            check("ciResult", ciResult, want);
        end
    end

    task automatic ci(input logic [3:0] cmd, input logic [1:0] idx, input logic [31:0] b, output logic [31:0] res);
        ciStart = 1; ciN = 8'h27; ciValueA = {19'b0, cmd, 7'b0, idx}; ciValueB = b;
        @(negedge clock_tb);
        res = ciResult;
        step();
        ciStart = 0;
        if (cmd == 4'h9) expThr = b[6:0];
        if (cmd == 4'hA) expEn = 0;
        if (cmd == 4'hB) expEn = 1;
    endtask

    task automatic readCheck(input string name, input logic [1:0] idx, input logic [31:0] want);
        logic [31:0] res;
        ci(4'h0, idx, 32'h0, res);
        check(name, res, want);
    endtask

    task automatic driveLine(input int mode, input int y);
        int n;
        n = lineLen(y);
        for (int x = 0; x < n; x++) begin
            validCamera = 1; camData = pix(mode, x, y);
            hsync = (y % 60 == 59 && x == n - 1);
            step();
        end
        validCamera = 0; camData = 0;
        if (y % 60 != 59) begin
            hsync = 1;
            step();
        end
        hsync = 0;
    endtask

    task automatic runFrame(input int mode, input logic take, input int nLines, input bit midCi,
                            input logic [31:0] midWant);
        logic wasEn;
        logic [31:0] res;
        wasEn = expEn;
        takeSignature = take; vsync = 1;
        step();
        vsync = 0;
        if (wasEn) expBusy = 1;
        for (int y = 0; y < nLines; y++) begin
            if (midCi && y == 200) begin
                ci(4'hB, 2'd0, 32'h0, res);
                readCheck("midStatus", 2'd3, midWant);
            end
            driveLine(mode, y);
        end
        if (nLines == 480) begin
            step();
            if (wasEn) modelComplete(frameHash(mode), take);
        end
    endtask

    initial begin
        reset = 0; hsync = 0; vsync = 0; validCamera = 0; camData = 0; takeSignature = 0;
        ciStart = 0; ciN = 0; ciValueA = 0; ciValueB = 0;
        modelReset();
        step(); step();
        checkOn = 1; reset = 1;
        step();
        readCheck("rstHash0", 2'd0, 32'h0);
        readCheck("rstHash1", 2'd1, 32'h0);
        readCheck("rstDist", 2'd2, 32'h0);
        readCheck("rstStatus", 2'd3, 32'h0);
        ci(4'hB, 2'd0, 32'h0, r);
        ci(4'h9, 2'd0, 32'h1, r);
        runFrame(0, 1, 480, 0, 0);
        readCheck("f1Hash0", 2'd0, 32'h77777777);
        readCheck("f1Hash1", 2'd1, 32'h77777777);
        readCheck("f1Dist", 2'd2, 32'h0);
        readCheck("f1Status", 2'd3, 32'h00000106);
        runFrame(0, 0, 480, 0, 0);
        readCheck("f2Hash0", 2'd0, 32'h77777777);
        readCheck("f2Dist", 2'd2, 32'h0);
        readCheck("f2Status", 2'd3, 32'h00000206);
        runFrame(1, 0, 480, 0, 0);
        readCheck("f3Hash0", 2'd0, 32'h0);
        readCheck("f3Hash1", 2'd1, 32'h0);
        readCheck("f3Dist", 2'd2, 32'd48);
        readCheck("f3Status", 2'd3, 32'h00000307);
        ci(4'h9, 2'd0, 32'd56, r);
        runFrame(3, 0, 480, 0, 0);
        readCheck("f4Hash0", 2'd0, 32'h80808080);
        readCheck("f4Hash1", 2'd1, 32'h80808080);
        readCheck("f4Dist", 2'd2, 32'd56);
        readCheck("f4Status", 2'd3, 32'h00000406);
        ci(4'hA, 2'd0, 32'h0, r);
        readCheck("disStatus", 2'd3, 32'h00000402);
        runFrame(0, 1, 120, 0, 0);
        step(); step();
        readCheck("disStatusAfter", 2'd3, 32'h00000402);
        readCheck("disHash0", 2'd0, 32'h80808080);
        ci(4'hB, 2'd0, 32'h0, r);
        runFrame(0, 0, 480, 1, 32'h0000040E);
        readCheck("f5Hash0", 2'd0, 32'h77777777);
        readCheck("f5Dist", 2'd2, 32'h0);
        readCheck("f5Status", 2'd3, 32'h00000506);
        ciStart = 1; ciN = 8'h26; ciValueA = 32'h0;
        @(negedge clock_tb);
        check("foreignDone", {31'b0, ciDone}, 32'h0);
        check("foreignResult", ciResult, 32'h0);
        step();
        ciStart = 1; ciN = 8'h27; ciValueA = {19'b0, 4'h5, 9'b0};
        @(negedge clock_tb);
        check("unknownDone", {31'b0, ciDone}, 32'h1);
        check("unknownResult", ciResult, 32'h0);
        step();
        ciStart = 0;
        runFrame(2, 0, 90, 0, 0);
        reset = 0;
        modelReset();
        readCheck("midRstHash0", 2'd0, 32'h0);
        readCheck("midRstDist", 2'd2, 32'h0);
        readCheck("midRstStatus", 2'd3, 32'h0);
        ciStart = 1; ciN = 8'h27; ciValueA = 32'h3;
        @(negedge clock_tb);
        check("midRstDone", {31'b0, ciDone}, 32'h1);
        step();
        ciStart = 0;
        reset = 1;
        step();
        ci(4'hB, 2'd0, 32'h0, r);
        runFrame(2, 1, 60, 0, 0);
        runFrame(2, 1, 480, 0, 0);
        readCheck("f6Hash0", 2'd0, expHash[31:0]);
        readCheck("f6Hash1", 2'd1, expHash[63:32]);
        readCheck("f6Dist", 2'd2, 32'h0);
        readCheck("f6Status", 2'd3, 32'h00000106);
        checkOn = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
